// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// pairing with issue addresses, and a small instruction buffer toward decode.
module fetch_unit #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = 32'h00400000,
  parameter int                 BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              req_ready,
  input  logic              rsp_valid,
  input  logic [31:0]       rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] fpc;
  logic [CNT_W-1:0]  count, outstanding, discard;
  logic [CNT_W:0]    used;

  logic [31:0]       fifo_instr [BUF_DEPTH];
  logic [ADDR_W-1:0] fifo_pc    [BUF_DEPTH];
  logic [PTR_W-1:0]  f_rd, f_wr;

  logic [ADDR_W-1:0] addr_q [BUF_DEPTH];
  logic [PTR_W-1:0]  q_rd, q_wr;

  logic hs, rsp_ok, rsp_drop, push, pop;

  // Buffered plus in-flight entries may never exceed the buffer size, so a
  // response always has a slot to land in.
  assign used      = {1'b0, count} + {1'b0, outstanding};
  assign req_valid = !reset && !redirect_valid && (used < (CNT_W+1)'(BUF_DEPTH));
  assign req_addr  = fpc & ALIGN_MASK;
  assign hs        = req_valid && req_ready;

  // A response with nothing outstanding is stale (e.g. issued before a reset).
  assign rsp_ok    = rsp_valid && (outstanding != '0);
  assign rsp_drop  = rsp_ok && (discard != '0);
  assign push      = rsp_ok && !rsp_drop && !redirect_valid;
  assign pop       = out_valid && out_ready && !redirect_valid;

  assign out_valid = (count != '0);
  assign out_instr = out_valid ? fifo_instr[f_rd] : '0;
  assign out_pc    = out_valid ? fifo_pc[f_rd]    : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc         <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      f_rd        <= '0;
      f_wr        <= '0;
      q_rd        <= '0;
      q_wr        <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the old path and must be dropped.
      fpc         <= redirect_pc & ALIGN_MASK;
      count       <= '0;
      f_rd        <= '0;
      f_wr        <= '0;
      q_rd        <= '0;
      q_wr        <= '0;
      discard     <= outstanding - CNT_W'(rsp_ok);
      outstanding <= outstanding - CNT_W'(rsp_ok);
    end else begin
      if (hs) begin
        fpc  <= fpc + ADDR_W'(4);
        q_wr <= q_wr + PTR_W'(1);
      end
      if (push)     q_rd    <= q_rd + PTR_W'(1);
      if (rsp_drop) discard <= discard - CNT_W'(1);
      if (push)     f_wr    <= f_wr + PTR_W'(1);
      if (pop)      f_rd    <= f_rd + PTR_W'(1);
      count       <= count + CNT_W'(push) - CNT_W'(pop);
      outstanding <= outstanding + CNT_W'(hs) - CNT_W'(rsp_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (hs) addr_q[q_wr] <= req_addr;
    if (push) begin
      fifo_instr[f_wr] <= rsp_data;
      fifo_pc[f_wr]    <= addr_q[q_rd];
    end
  end

endmodule
